// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared opcode codes (inst[6:2]) and the canonical NOP encoding
// used by the ID/EX pipeline register and its load-use hazard detector.
package id_ex_stage_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    // addi x0, x0, 0: what EX sees whenever a bubble occupies the stage
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Only register-register ALU ops, stores and branches actually read rs2;
    // OP_IMM and LOAD reuse those bits as immediate, so they never create a
    // dependency through the rs2 field.
    function automatic logic uses_rs2(input logic [4:0] opc);
        return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/ld_use_hazard.sv
// ld_use_hazard: purely combinational load-use detector. Flags when the load
// sitting in EX writes a non-zero register that the instruction in ID reads.
module ld_use_hazard
    import id_ex_stage_pkg::*;
#(
    parameter int RFW = 5,
    parameter int IW  = 32
) (
    input  logic [IW-1:0] ex_inst,
    input  logic          ex_valid,
    input  logic [IW-1:0] id_inst,
    input  logic          id_valid,
    output logic          hazard
);

    logic [4:0]     ex_opc;
    logic [4:0]     id_opc;
    logic [RFW-1:0] ex_rd;
    logic [RFW-1:0] id_rs1;
    logic [RFW-1:0] id_rs2;
    logic           unused_fields;

    assign ex_opc = ex_inst[6:2];
    assign id_opc = id_inst[6:2];
    assign ex_rd  = ex_inst[7 +: RFW];
    assign id_rs1 = id_inst[15 +: RFW];
    assign id_rs2 = id_inst[20 +: RFW];

    // funct/immediate bits play no part in the dependency check
    assign unused_fields = ^{ex_inst, id_inst};

    // x0 is never a real destination, so a load to x0 can never cause a stall
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && (ex_opc == OPC_LOAD) && (ex_rd != '0) && id_valid) begin
            hazard = (id_rs1 == ex_rd) || ((id_rs2 == ex_rd) && uses_rs2(id_opc));
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble injection.
// Operands arrive already forwarded; forwarding cannot cover a LOAD result,
// so a dependent instruction is held in ID while LDUSE_BUBBLES NOPs go to EX.
// Optional feature: define STALL_CNT_EN to build the saturating bubble counter
// behind stall_cnt; otherwise stall_cnt is tied to zero.
// LDUSE_BUBBLES must be 1..3 (bubble count is a 2-bit down-counter).
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int RFW           = 5,
    parameter int DW            = 32,
    parameter int IW            = 32,
    parameter int AW            = 32,
    parameter int LDUSE_BUBBLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [IW-1:0] id_inst,
    input  logic [AW-1:0] id_pc,
    input  logic [DW-1:0] id_imm,
    input  logic [DW-1:0] id_rs1data,
    input  logic [DW-1:0] id_rs2data,
    input  logic          ex_ready,
    input  logic          flush,
    output logic          ex_valid,
    output logic [IW-1:0] ex_inst,
    output logic [AW-1:0] ex_pc,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_rs1data,
    output logic [DW-1:0] ex_rs2data,
    output logic          id_stall,
    output logic [31:0]   stall_cnt
);

    localparam logic [IW-1:0] NOP           = IW'(NOP_INST);
    localparam logic [1:0]    BUBBLE_RELOAD = 2'(LDUSE_BUBBLES - 1);

    logic          ex_valid_q,   ex_valid_d;
    logic [IW-1:0] ex_inst_q,    ex_inst_d;
    logic [AW-1:0] ex_pc_q,      ex_pc_d;
    logic [DW-1:0] ex_imm_q,     ex_imm_d;
    logic [DW-1:0] ex_rs1data_q, ex_rs1data_d;
    logic [DW-1:0] ex_rs2data_q, ex_rs2data_d;
    logic [1:0]    cnt_q,        cnt_d;
    logic          hazard;

    ld_use_hazard #(
        .RFW (RFW),
        .IW  (IW)
    ) u_ld_use_hazard (
        .ex_inst  (ex_inst_q),
        .ex_valid (ex_valid_q),
        .id_inst  (id_inst),
        .id_valid (id_valid),
        .hazard   (hazard)
    );

    // Priority mux: flush > downstream stall > owed bubbles > new hazard > advance
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_inst_d    = ex_inst_q;
        ex_pc_d      = ex_pc_q;
        ex_imm_d     = ex_imm_q;
        ex_rs1data_d = ex_rs1data_q;
        ex_rs2data_d = ex_rs2data_q;
        cnt_d        = cnt_q;
        id_stall     = 1'b0;
        if (flush) begin
            ex_valid_d = 1'b0;
            ex_inst_d  = NOP;
            cnt_d      = 2'd0;
        end else if (!ex_ready) begin
            id_stall = 1'b1;
        end else if (cnt_q != 2'd0) begin
            ex_valid_d = 1'b0;
            ex_inst_d  = NOP;
            cnt_d      = cnt_q - 2'd1;
            id_stall   = 1'b1;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            ex_inst_d  = NOP;
            cnt_d      = BUBBLE_RELOAD;
            id_stall   = 1'b1;
        end else begin
            ex_valid_d   = id_valid;
            ex_inst_d    = id_valid ? id_inst : NOP;
            ex_pc_d      = id_pc;
            ex_imm_d     = id_imm;
            ex_rs1data_d = id_rs1data;
            ex_rs2data_d = id_rs2data;
        end
    end

    // Pipeline register and bubble down-counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_inst_q    <= NOP;
            ex_pc_q      <= '0;
            ex_imm_q     <= '0;
            ex_rs1data_q <= '0;
            ex_rs2data_q <= '0;
            cnt_q        <= 2'd0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_inst_q    <= ex_inst_d;
            ex_pc_q      <= ex_pc_d;
            ex_imm_q     <= ex_imm_d;
            ex_rs1data_q <= ex_rs1data_d;
            ex_rs2data_q <= ex_rs2data_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef STALL_CNT_EN
    logic        bubble_inject;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A bubble counts only when the pipe actually advances with a NOP
    assign bubble_inject = !flush && ex_ready && ((cnt_q != 2'd0) || hazard);

    // Saturating increment so the counter never wraps back to a small value
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bubble_inject && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Bubble counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

    assign ex_valid   = ex_valid_q;
    assign ex_inst    = ex_inst_q;
    assign ex_pc      = ex_pc_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs1data = ex_rs1data_q;
    assign ex_rs2data = ex_rs2data_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed load-use scenarios plus a randomized run checked
// against a behavioural model of the ID/EX register (default parameters).
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int          BUBBLES  = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [6:0]  LOAD7    = 7'h03;
    localparam logic [6:0]  OPIMM7   = 7'h13;
    localparam logic [6:0]  OP7      = 7'h33;
    localparam logic [6:0]  STORE7   = 7'h23;
    localparam logic [6:0]  BRANCH7  = 7'h63;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_inst, id_pc, id_imm, id_rs1data, id_rs2data;
    logic        ex_ready, flush;
    logic        ex_valid;
    logic [31:0] ex_inst, ex_pc, ex_imm, ex_rs1data, ex_rs2data;
    logic        id_stall;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    int bubbles_seen = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_inst    (id_inst),
        .id_pc      (id_pc),
        .id_imm     (id_imm),
        .id_rs1data (id_rs1data),
        .id_rs2data (id_rs2data),
        .ex_ready   (ex_ready),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_inst    (ex_inst),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1data (ex_rs1data),
        .ex_rs2data (ex_rs2data),
        .id_stall   (id_stall),
        .stall_cnt  (stall_cnt)
    );

    // Build an instruction word from its opcode and register fields
    function automatic logic [31:0] enc(input logic [6:0] opc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, opc};
    endfunction

    // stall_cnt only counts when the optional counter is built
    function automatic logic [31:0] exp_scnt();
`ifdef STALL_CNT_EN
        return 32'(bubbles_seen);
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        id_valid   = v;
        id_inst    = inst;
        id_pc      = pc;
        id_imm     = $urandom;
        id_rs1data = $urandom;
        id_rs2data = $urandom;
    endtask

    // T1: two reset cycles leave EX empty and the counter clear
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        set_id(1'b0, NOP, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid: got %b want 0", ex_valid); end
        checks++; if (ex_inst !== NOP) begin errors++; $display("[TB] FAIL reset_ex_inst: got %h want %h", ex_inst, NOP); end
        checks++; if (ex_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_ex_pc: got %h want 0", ex_pc); end
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_stall: got %b want 0", id_stall); end
        tick();
    endtask

    // T2: lw x5 in EX, dependent add in ID -> two bubbles then the add
    task automatic test_load_use();
        set_id(1'b1, enc(LOAD7, 5'd5, 5'd1, 5'd0), 32'h100);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_inst !== enc(LOAD7, 5'd5, 5'd1, 5'd0)) begin errors++; $display("[TB] FAIL lu_load_in_ex: got v=%b %h", ex_valid, ex_inst); end
        set_id(1'b1, enc(OP7, 5'd6, 5'd5, 5'd7), 32'h104);
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall_0: got %b want 1", id_stall); end
        tick(); bubbles_seen++;
        checks++; if (ex_valid !== 1'b0 || ex_inst !== NOP) begin errors++; $display("[TB] FAIL lu_bubble_1: got v=%b %h want v=0 %h", ex_valid, ex_inst, NOP); end
        checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall_1: got %b want 1", id_stall); end
        tick(); bubbles_seen++;
        checks++; if (ex_valid !== 1'b0 || ex_inst !== NOP) begin errors++; $display("[TB] FAIL lu_bubble_2: got v=%b %h want v=0 %h", ex_valid, ex_inst, NOP); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_2: got %b want 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_inst !== enc(OP7, 5'd6, 5'd5, 5'd7) || ex_pc !== 32'h104) begin errors++; $display("[TB] FAIL lu_add_in_ex: got v=%b %h pc=%h", ex_valid, ex_inst, ex_pc); end
        checks++; if (stall_cnt !== exp_scnt()) begin errors++; $display("[TB] FAIL lu_stall_cnt: got %0d want %0d", stall_cnt, exp_scnt()); end
    endtask

    // T3/T4: load to x0, and OP_IMM whose immediate bits alias rs2, never stall
    task automatic test_no_hazard();
        set_id(1'b1, enc(LOAD7, 5'd0, 5'd1, 5'd0), 32'h200);
        tick();
        set_id(1'b1, enc(OP7, 5'd6, 5'd0, 5'd1), 32'h204);
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL x0_stall: got %b want 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_inst !== enc(OP7, 5'd6, 5'd0, 5'd1)) begin errors++; $display("[TB] FAIL x0_add_in_ex: got v=%b %h", ex_valid, ex_inst); end
        set_id(1'b1, enc(LOAD7, 5'd5, 5'd1, 5'd0), 32'h300);
        tick();
        set_id(1'b1, enc(OPIMM7, 5'd6, 5'd1, 5'd5), 32'h304);
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL opimm_stall: got %b want 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h304) begin errors++; $display("[TB] FAIL opimm_in_ex: got v=%b pc=%h", ex_valid, ex_pc); end
        set_id(1'b1, enc(LOAD7, 5'd9, 5'd1, 5'd0), 32'h400);
        tick();
        set_id(1'b1, enc(STORE7, 5'd0, 5'd2, 5'd9), 32'h404);
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL store_rs2_stall: got %b want 1", id_stall); end
        tick(); bubbles_seen++;
        tick(); bubbles_seen++;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h404) begin errors++; $display("[TB] FAIL store_in_ex: got v=%b pc=%h", ex_valid, ex_pc); end
    endtask

    // T5: flush on the first bubble cancels the remaining bubble
    task automatic test_flush_bubble();
        set_id(1'b1, enc(LOAD7, 5'd5, 5'd1, 5'd0), 32'h500);
        tick();
        set_id(1'b1, enc(OP7, 5'd6, 5'd5, 5'd7), 32'h504);
        tick(); bubbles_seen++;
        flush = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %b want 0", id_stall); end
        tick();
        flush = 1'b0;
        checks++; if (ex_valid !== 1'b0 || ex_inst !== NOP) begin errors++; $display("[TB] FAIL flush_ex: got v=%b %h", ex_valid, ex_inst); end
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_after_stall: got %b want 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h504) begin errors++; $display("[TB] FAIL flush_refill: got v=%b pc=%h", ex_valid, ex_pc); end
        checks++; if (stall_cnt !== exp_scnt()) begin errors++; $display("[TB] FAIL flush_stall_cnt: got %0d want %0d", stall_cnt, exp_scnt()); end
    endtask

    // T6: downstream stall during bubble 1 freezes everything for 3 cycles
    task automatic test_ex_ready_hold();
        set_id(1'b1, enc(LOAD7, 5'd5, 5'd1, 5'd0), 32'h600);
        tick();
        set_id(1'b1, enc(OP7, 5'd6, 5'd5, 5'd7), 32'h604);
        tick(); bubbles_seen++;
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall_%0d: got %b want 1", i, id_stall); end
            tick();
            checks++; if (ex_valid !== 1'b0 || ex_inst !== NOP || stall_cnt !== exp_scnt()) begin errors++; $display("[TB] FAIL hold_ex_%0d: got v=%b %h cnt=%0d", i, ex_valid, ex_inst, stall_cnt); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_resume_stall: got %b want 1", id_stall); end
        tick(); bubbles_seen++;
        checks++; if (ex_valid !== 1'b0 || id_stall !== 1'b0) begin errors++; $display("[TB] FAIL hold_bubble_2: got v=%b stall=%b", ex_valid, id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h604) begin errors++; $display("[TB] FAIL hold_add_in_ex: got v=%b pc=%h", ex_valid, ex_pc); end
        checks++; if (stall_cnt !== exp_scnt()) begin errors++; $display("[TB] FAIL hold_stall_cnt: got %0d want %0d", stall_cnt, exp_scnt()); end
    endtask

    // Random traffic compared against a model built from the stage's rules
    task automatic test_random();
        logic        m_valid;
        logic [31:0] m_inst, m_pc, m_imm, m_rs1, m_rs2;
        int          m_left;
        logic        haz, exp_stall;
        logic [6:0]  opcs [5] = '{LOAD7, OPIMM7, OP7, STORE7, BRANCH7};

        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        set_id(1'b0, NOP, 32'h0);
        tick();
        rst = 1'b0;
        bubbles_seen = 0;
        checks++; if (stall_cnt !== 32'h0) begin errors++; $display("[TB] FAIL rand_reset_cnt: got %0d want 0", stall_cnt); end
        m_valid = 1'b0; m_inst = NOP; m_pc = '0; m_imm = '0; m_rs1 = '0; m_rs2 = '0; m_left = 0;

        for (int i = 0; i < 400; i++) begin
            set_id(($urandom_range(0, 7) != 0),
                   enc(opcs[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))),
                   $urandom);
            ex_ready = ($urandom_range(0, 4) != 0);
            flush    = ($urandom_range(0, 19) == 0);

            haz = m_valid && (m_inst[6:0] == LOAD7) && (m_inst[11:7] != 5'd0) && id_valid &&
                  ((id_inst[19:15] == m_inst[11:7]) ||
                   ((id_inst[24:20] == m_inst[11:7]) && (id_inst[6:0] inside {OP7, STORE7, BRANCH7})));

            if (flush) begin
                exp_stall = 1'b0; m_valid = 1'b0; m_inst = NOP; m_left = 0;
            end else if (!ex_ready) begin
                exp_stall = 1'b1;
            end else if (m_left > 0) begin
                exp_stall = 1'b1; m_valid = 1'b0; m_inst = NOP; m_left--; bubbles_seen++;
            end else if (haz) begin
                exp_stall = 1'b1; m_valid = 1'b0; m_inst = NOP; m_left = BUBBLES - 1; bubbles_seen++;
            end else begin
                exp_stall = 1'b0;
                m_valid = id_valid; m_inst = id_valid ? id_inst : NOP;
                m_pc = id_pc; m_imm = id_imm; m_rs1 = id_rs1data; m_rs2 = id_rs2data;
            end

            #1;
            checks++; if (id_stall !== exp_stall) begin errors++; $display("[TB] FAIL rand_stall[%0d]: got %b want %b", i, id_stall, exp_stall); end
            tick();
            checks++; if (ex_valid !== m_valid) begin errors++; $display("[TB] FAIL rand_valid[%0d]: got %b want %b", i, ex_valid, m_valid); end
            checks++; if (ex_inst !== m_inst) begin errors++; $display("[TB] FAIL rand_inst[%0d]: got %h want %h", i, ex_inst, m_inst); end
            checks++; if (stall_cnt !== exp_scnt()) begin errors++; $display("[TB] FAIL rand_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_scnt()); end
            if (m_valid) begin
                checks++; if ({ex_pc, ex_imm, ex_rs1data, ex_rs2data} !== {m_pc, m_imm, m_rs1, m_rs2}) begin errors++; $display("[TB] FAIL rand_data[%0d]: got %h %h %h %h want %h %h %h %h", i, ex_pc, ex_imm, ex_rs1data, ex_rs2data, m_pc, m_imm, m_rs1, m_rs2); end
            end
        end
        flush = 1'b0; ex_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush_bubble();
        test_ex_ready_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
